mixed_radix_addr_gen: RTL and testbench
=======================================

Name: mixed_radix_addr_gen

Overview:
- Parametrised output-reorder address generator for the PUSCH mixed-radix DFT (N = 2^a·3^b·5^c).
- Replaces the fixed pow2 × pow3x5 transpose counter at the radix-2 output. Adds three runtime modes: natural order, two-factor transpose and full three-factor digit reversal.
- Adds a start/done handshake, valid/ready backpressure, abort and configuration checking.
- Sits between the last FFT stage and the output/result memory write port.

Parameters:
- ADDR_W, 11, address width; maximum N is 2^ADDR_W.
- P2_W, 9, width of cfg_pow2.
- P3_W, 8, width of cfg_pow3.
- P5_W, 5, width of cfg_pow5.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- abort  in  1  synchronous cancel
- cfg_mode  in  2  0 natural, 1 two-factor transpose, 2 three-factor digit reversal, 3 reserved (treated as 0)
- cfg_pow2  in  P2_W  radix-2 factor P2
- cfg_pow3  in  P3_W  radix-3 factor P3
- cfg_pow5  in  P5_W  radix-5 factor P5
- addr  out  ADDR_W  write address
- addr_valid  out  1  addr is valid
- addr_ready  in  1  consumer accepts addr
- addr_last  out  1  addr is the final address of the frame
- done  out  1  one-cycle pulse after the final handshake
- busy  out  1  high in SETUP and RUN
- cfg_err  out  1  one-cycle pulse on illegal configuration

Behaviour:
- Reset values: addr=0, addr_valid=0, addr_last=0, done=0, busy=0, cfg_err=0, all counters 0, state IDLE.

States:
- IDLE: start=1 latches mode and pow values → SETUP. A pow value of 0 is latched as 1.
- SETUP (1 cycle):
  - Registers N = P2·P3·P5 and strides.
  - Mode 0: single counter, stride 1.
  - Mode 1: fast index a over P2 with stride P3·P5; slow index j over P3·P5 with stride 1.
  - Mode 2: a over P2 with stride P3·P5; b over P3 with stride P5; c over P5 with stride 1. Nesting order is a fastest, c slowest.
  - If N > 2^ADDR_W: cfg_err=1 for that cycle, then → IDLE with no stream.
  - Otherwise → RUN.
- RUN:
  - Latency: addr_valid rises the cycle after SETUP, i.e. 2 cycles after the start cycle.
  - Address computation: addr = Σ index·stride, produced by stride accumulators only, with no multiplier in the run path.
    - Fast index wrap: its accumulator returns to the base.
    - The next slower index increments and its stride is added to the base.
  - Handshake: the address advances only on addr_valid & addr_ready. While addr_ready=0, addr, addr_valid and addr_last hold stable.
  - addr_last=1 exactly on the N-th address.
  - A handshake on the last address → IDLE. done=1 on the following cycle, and addr_valid=0 on that cycle.
- Start handling:
  - start while busy is ignored.
  - start in the done cycle is accepted, because the state is already IDLE.
- abort:
  - In SETUP or RUN, abort → IDLE next cycle; addr_valid drops and counters clear.
  - No done and no cfg_err are produced.
  - abort has priority over a simultaneous handshake.
- N=1: one address 0 with addr_last=1.
- Async rst mid-run: all outputs go to their reset values immediately; no done pulse.

Optional Feature:
- Macro: ADDR_GEN_ROW_LAST_EN.
- Defined:
  - Adds output row_last (1 bit).
  - row_last is high while addr_valid and the fastest index equals P2−1, i.e. the end of each radix-2 row.
  - It is held stable under backpressure like addr.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- mode0, P2=4, P3=1, P5=1, ready=1 → addr 0,1,2,3 on consecutive cycles; addr_last on 3; done one cycle later; first valid 2 cycles after start.
- mode1, P2=2, P3=3, P5=1 → addr 0,3,1,4,2,5; addr_last on 5.
- mode2, P2=2, P3=3, P5=5 (N=30) → 0,15,5,20,10,25,1,16,6,21,11,26,… ending 29; exactly 30 handshakes; done once.
- mode2 N=30 with addr_ready low for cycles 5–7 of RUN → addr, addr_valid and addr_last frozen; sequence unchanged, no skipped or duplicated address; same for row_last with ADDR_GEN_ROW_LAST_EN.
- P2=256, P3=9, P5=1 (N=2304 > 2048) → cfg_err pulse in SETUP; busy low afterwards; addr_valid never rises.
- Abort on the 10th address of an N=30 stream → addr_valid=0 next cycle, no done. Then rst asserted mid-run on a new frame → outputs zero immediately. Then a new start → the sequence restarts from 0.

Source files
------------

// File: rtl/mixed_radix_addr_gen_if.sv
// Start/config/address handshake bundle for mixed_radix_addr_gen.
// row_last is present only when ADDR_GEN_ROW_LAST_EN is defined.
interface mixed_radix_addr_gen_if #(
  parameter int ADDR_W = 11,
  parameter int P2_W   = 9,
  parameter int P3_W   = 8,
  parameter int P5_W   = 5
);
  logic              start;
  logic              abort;
  logic [1:0]        cfg_mode;
  logic [P2_W-1:0]   cfg_pow2;
  logic [P3_W-1:0]   cfg_pow3;
  logic [P5_W-1:0]   cfg_pow5;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;
  logic              addr_last;
  logic              done;
  logic              busy;
  logic              cfg_err;
`ifdef ADDR_GEN_ROW_LAST_EN
  logic              row_last;

  modport master (
    output start, abort, cfg_mode, cfg_pow2, cfg_pow3, cfg_pow5, addr_ready,
    input  addr, addr_valid, addr_last, done, busy, cfg_err, row_last
  );
  modport slave (
    input  start, abort, cfg_mode, cfg_pow2, cfg_pow3, cfg_pow5, addr_ready,
    output addr, addr_valid, addr_last, done, busy, cfg_err, row_last
  );
`else
  modport master (
    output start, abort, cfg_mode, cfg_pow2, cfg_pow3, cfg_pow5, addr_ready,
    input  addr, addr_valid, addr_last, done, busy, cfg_err
  );
  modport slave (
    input  start, abort, cfg_mode, cfg_pow2, cfg_pow3, cfg_pow5, addr_ready,
    output addr, addr_valid, addr_last, done, busy, cfg_err
  );
`endif
endinterface

// File: rtl/mixed_radix_addr_gen.sv
// Output-reorder address generator for the mixed-radix DFT (natural, transpose, digit reversal).
// Optional row_last output enabled by macro ADDR_GEN_ROW_LAST_EN.
module mixed_radix_addr_gen #(
  parameter int ADDR_W = 11,
  parameter int P2_W   = 9,
  parameter int P3_W   = 8,
  parameter int P5_W   = 5
) (
  input  logic clk,
  input  logic rst,
  mixed_radix_addr_gen_if.slave bus
);
  localparam int LW = ADDR_W + 1;
  localparam int NW = P2_W + P3_W + P5_W;
  localparam logic [NW-1:0] N_MAX = NW'(1'b1) << ADDR_W;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, RUN = 2'd2} state_t;

  state_t            state_r;
  logic [1:0]        mode_r;
  logic [P2_W-1:0]   p2_r;
  logic [P3_W-1:0]   p3_r;
  logic [P5_W-1:0]   p5_r;
  logic [LW-1:0]     len_a_r, len_b_r, len_c_r;
  logic [LW-1:0]     idx_a_r, idx_b_r, idx_c_r;
  logic [ADDR_W-1:0] st_a_r, st_b_r, st_c_r;
  logic [ADDR_W-1:0] base_ab_r, base_c_r, addr_r;
  logic              addr_valid_r, addr_last_r, done_r, busy_r, cfg_err_r, row_last_r;

  logic [P2_W-1:0]   p2_in_s;
  logic [P3_W-1:0]   p3_in_s;
  logic [P5_W-1:0]   p5_in_s;
  logic [NW-1:0]     n_in_s, n_s;
  logic [LW-1:0]     p35_s;
  logic [LW-1:0]     len_a_s, len_b_s, len_c_s;
  logic [ADDR_W-1:0] st_a_s, st_b_s, st_c_s;
  logic              hs_s, finish_s, clear_s;
  logic [LW-1:0]     nxt_a_s, nxt_b_s, nxt_c_s;
  logic [ADDR_W-1:0] nxt_ab_s, nxt_cb_s, nxt_addr_s;
  logic              nxt_last_s;

  // A zero pow value stands for a factor of 1.
  assign p2_in_s = (bus.cfg_pow2 == '0) ? P2_W'(1'b1) : bus.cfg_pow2;
  assign p3_in_s = (bus.cfg_pow3 == '0) ? P3_W'(1'b1) : bus.cfg_pow3;
  assign p5_in_s = (bus.cfg_pow5 == '0) ? P5_W'(1'b1) : bus.cfg_pow5;
  assign n_in_s  = NW'(p2_in_s) * NW'(p3_in_s) * NW'(p5_in_s);
  assign n_s     = NW'(p2_r) * NW'(p3_r) * NW'(p5_r);
  assign p35_s   = LW'(p3_r) * LW'(p5_r);

  assign hs_s     = addr_valid_r & bus.addr_ready;
  assign finish_s = (state_r == RUN) && hs_s && addr_last_r && !bus.abort;
  assign clear_s  = ((state_r != IDLE) && bus.abort) || finish_s ||
                    ((state_r == SETUP) && cfg_err_r);

  // Per-mode loop lengths and strides, resolved once in SETUP.
  always_comb begin
    len_a_s = LW'(n_s);
    len_b_s = LW'(1'b1);
    len_c_s = LW'(1'b1);
    st_a_s  = ADDR_W'(1'b1);
    st_b_s  = '0;
    st_c_s  = '0;
    case (mode_r)
      2'd1: begin
        len_a_s = LW'(p2_r);
        st_a_s  = ADDR_W'(p35_s);
        len_b_s = p35_s;
        st_b_s  = ADDR_W'(1'b1);
      end
      2'd2: begin
        len_a_s = LW'(p2_r);
        st_a_s  = ADDR_W'(p35_s);
        len_b_s = LW'(p3_r);
        st_b_s  = ADDR_W'(p5_r);
        len_c_s = LW'(p5_r);
        st_c_s  = ADDR_W'(1'b1);
      end
      default: begin
        len_a_s = LW'(n_s);
      end
    endcase
  end

  // Stride-accumulator step: fast index wraps back to the base of the next slower index.
  always_comb begin
    nxt_a_s    = idx_a_r + LW'(1'b1);
    nxt_b_s    = idx_b_r;
    nxt_c_s    = idx_c_r;
    nxt_ab_s   = base_ab_r;
    nxt_cb_s   = base_c_r;
    nxt_addr_s = addr_r + st_a_r;
    if (idx_a_r != len_a_r - LW'(1'b1)) begin
      nxt_a_s = idx_a_r + LW'(1'b1);
    end else if (idx_b_r != len_b_r - LW'(1'b1)) begin
      nxt_a_s    = '0;
      nxt_b_s    = idx_b_r + LW'(1'b1);
      nxt_ab_s   = base_ab_r + st_b_r;
      nxt_addr_s = base_ab_r + st_b_r;
    end else begin
      nxt_a_s    = '0;
      nxt_b_s    = '0;
      nxt_c_s    = idx_c_r + LW'(1'b1);
      nxt_cb_s   = base_c_r + st_c_r;
      nxt_ab_s   = base_c_r + st_c_r;
      nxt_addr_s = base_c_r + st_c_r;
    end
    nxt_last_s = (nxt_a_s == len_a_r - LW'(1'b1)) && (nxt_b_s == len_b_r - LW'(1'b1)) &&
                 (nxt_c_s == len_c_r - LW'(1'b1));
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;   mode_r <= 2'd0;
      p2_r <= '0;        p3_r <= '0;        p5_r <= '0;
      len_a_r <= '0;     len_b_r <= '0;     len_c_r <= '0;
      idx_a_r <= '0;     idx_b_r <= '0;     idx_c_r <= '0;
      st_a_r <= '0;      st_b_r <= '0;      st_c_r <= '0;
      base_ab_r <= '0;   base_c_r <= '0;    addr_r <= '0;
      addr_valid_r <= 1'b0; addr_last_r <= 1'b0; row_last_r <= 1'b0;
      done_r <= 1'b0;    busy_r <= 1'b0;    cfg_err_r <= 1'b0;
    end else begin
      done_r    <= finish_s;
      cfg_err_r <= 1'b0;
      if (clear_s) begin
        state_r <= IDLE;
        idx_a_r <= '0;     idx_b_r <= '0;     idx_c_r <= '0;
        base_ab_r <= '0;   base_c_r <= '0;    addr_r <= '0;
        addr_valid_r <= 1'b0; addr_last_r <= 1'b0; row_last_r <= 1'b0;
        busy_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.start) begin
              mode_r    <= bus.cfg_mode;
              p2_r      <= p2_in_s;
              p3_r      <= p3_in_s;
              p5_r      <= p5_in_s;
              cfg_err_r <= (n_in_s > N_MAX);
              busy_r    <= 1'b1;
              state_r   <= SETUP;
            end else begin
              state_r <= IDLE;
            end
          end
          SETUP: begin
            len_a_r <= len_a_s;  len_b_r <= len_b_s;  len_c_r <= len_c_s;
            st_a_r  <= st_a_s;   st_b_r  <= st_b_s;   st_c_r  <= st_c_s;
            idx_a_r <= '0;       idx_b_r <= '0;       idx_c_r <= '0;
            base_ab_r <= '0;     base_c_r <= '0;      addr_r <= '0;
            addr_valid_r <= 1'b1;
            addr_last_r  <= (n_s == NW'(1'b1));
            row_last_r   <= (p2_r == P2_W'(1'b1));
            state_r      <= RUN;
          end
          RUN: begin
            if (hs_s) begin
              idx_a_r <= nxt_a_s;  idx_b_r <= nxt_b_s;  idx_c_r <= nxt_c_s;
              base_ab_r <= nxt_ab_s;
              base_c_r  <= nxt_cb_s;
              addr_r    <= nxt_addr_s;
              addr_last_r <= nxt_last_s;
              row_last_r  <= (nxt_a_s == LW'(p2_r) - LW'(1'b1));
            end else begin
              addr_r <= addr_r;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.addr       = addr_r;
  assign bus.addr_valid = addr_valid_r;
  assign bus.addr_last  = addr_last_r;
  assign bus.done       = done_r;
  assign bus.busy       = busy_r;
  assign bus.cfg_err    = cfg_err_r;
`ifdef ADDR_GEN_ROW_LAST_EN
  assign bus.row_last   = row_last_r;
`else
  logic unused_row_last_s;
  assign unused_row_last_s = row_last_r;
`endif

endmodule

// File: tb/tb_mixed_radix_addr_gen.sv
// Directed, table-driven bench for mixed_radix_addr_gen with hand-computed address sequences.
module tb_mixed_radix_addr_gen;
  localparam int ADDR_W = 11;
  localparam int P2_W   = 9;
  localparam int P3_W   = 8;
  localparam int P5_W   = 5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mixed_radix_addr_gen_if #(.ADDR_W(ADDR_W), .P2_W(P2_W), .P3_W(P3_W), .P5_W(P5_W)) bus ();

  mixed_radix_addr_gen #(.ADDR_W(ADDR_W), .P2_W(P2_W), .P3_W(P3_W), .P5_W(P5_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int         p2;
    int         p3;
    int         p5;
    int         n;
    int         off;
  } vec_t;

  vec_t vecs[6];
  int   exp_addr[$] = '{
    0, 1, 2, 3,
    0, 3, 1, 4, 2, 5,
    0, 15, 5, 20, 10, 25, 1, 16, 6, 21, 11, 26, 2, 17, 7, 22, 12, 27,
    3, 18, 8, 23, 13, 28, 4, 19, 9, 24, 14, 29,
    0, 1, 2,
    0,
    0, 5, 1, 6, 2, 7, 3, 8, 4, 9
  };

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input int p2, input int p3, input int p5);
    bus.cfg_mode = mode;
    bus.cfg_pow2 = P2_W'(p2);
    bus.cfg_pow3 = P3_W'(p3);
    bus.cfg_pow5 = P5_W'(p5);
  endtask

  task automatic run_vec(input int i);
    set_cfg(vecs[i].mode, vecs[i].p2, vecs[i].p3, vecs[i].p5);
    bus.addr_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("setup_busy", int'(bus.busy), 1);
    chk("setup_valid", int'(bus.addr_valid), 0);
    step();
    for (int k = 0; k < vecs[i].n; k++) begin
      chk("valid", int'(bus.addr_valid), 1);
      chk("addr", int'(bus.addr), exp_addr[vecs[i].off + k]);
      chk("last", int'(bus.addr_last), (k == vecs[i].n - 1) ? 1 : 0);
      step();
    end
    chk("done", int'(bus.done), 1);
    chk("valid_after", int'(bus.addr_valid), 0);
    chk("busy_after", int'(bus.busy), 0);
    step();
    chk("done_pulse", int'(bus.done), 0);
  endtask

  initial begin
    int k;
    checks   = 0;
    failures = 0;
    vecs[0] = '{2'd0, 4, 1, 1, 4, 0};
    vecs[1] = '{2'd1, 2, 3, 1, 6, 4};
    vecs[2] = '{2'd2, 2, 3, 5, 30, 10};
    vecs[3] = '{2'd3, 3, 1, 1, 3, 40};
    vecs[4] = '{2'd2, 0, 0, 0, 1, 43};
    vecs[5] = '{2'd1, 2, 1, 5, 10, 44};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.addr_ready = 1'b0;
    set_cfg(2'd0, 0, 0, 0);
    step();
    step();
    chk("rst_addr", int'(bus.addr), 0);
    chk("rst_valid", int'(bus.addr_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(i);

    // Backpressure on RUN cycles 5..7, plus a start while busy that must be ignored.
    set_cfg(2'd2, 2, 3, 5);
    bus.addr_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    k = 0;
    for (int c = 1; c <= 40 && k < 30; c++) begin
      bus.addr_ready = !(c >= 5 && c <= 7);
      bus.start = (c == 3);
      chk("bp_valid", int'(bus.addr_valid), 1);
      chk("bp_addr", int'(bus.addr), exp_addr[10 + k]);
      chk("bp_last", int'(bus.addr_last), (k == 29) ? 1 : 0);
`ifdef ADDR_GEN_ROW_LAST_EN
      chk("bp_row_last", int'(bus.row_last), k % 2);
`endif
      if (bus.addr_ready) k++;
      step();
    end
    bus.start = 1'b0;
    bus.addr_ready = 1'b1;
    chk("bp_done", int'(bus.done), 1);
    chk("bp_valid_after", int'(bus.addr_valid), 0);

    // Start in the done cycle is accepted.
    set_cfg(2'd0, 2, 1, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("dc_busy", int'(bus.busy), 1);
    step();
    chk("dc_addr0", int'(bus.addr), 0);
    chk("dc_valid", int'(bus.addr_valid), 1);
    step();
    chk("dc_addr1", int'(bus.addr), 1);
    chk("dc_last", int'(bus.addr_last), 1);
    step();
    chk("dc_done", int'(bus.done), 1);
    step();

    // Oversized configuration: N = 2304.
    set_cfg(2'd0, 256, 9, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("err_pulse", int'(bus.cfg_err), 1);
    chk("err_busy", int'(bus.busy), 1);
    step();
    chk("err_clear", int'(bus.cfg_err), 0);
    chk("err_busy_low", int'(bus.busy), 0);
    chk("err_valid", int'(bus.addr_valid), 0);
    step();
    chk("err_valid2", int'(bus.addr_valid), 0);
    chk("err_done", int'(bus.done), 0);

    // Abort on the 10th address of an N=30 stream, racing a handshake.
    set_cfg(2'd2, 2, 3, 5);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    for (int j = 0; j < 9; j++) step();
    chk("ab_addr10", int'(bus.addr), 21);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_valid", int'(bus.addr_valid), 0);
    chk("ab_busy", int'(bus.busy), 0);
    chk("ab_done", int'(bus.done), 0);
    step();
    chk("ab_done2", int'(bus.done), 0);
    chk("ab_err", int'(bus.cfg_err), 0);

    // Async reset mid-run on a new frame.
    set_cfg(2'd0, 4, 1, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("pre_rst_addr", int'(bus.addr), 1);
    rst = 1'b1;
    #1;
    chk("arst_addr", int'(bus.addr), 0);
    chk("arst_valid", int'(bus.addr_valid), 0);
    chk("arst_busy", int'(bus.busy), 0);
    step();
    rst = 1'b0;
    step();
    chk("arst_done", int'(bus.done), 0);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
